// File: rtl/rf_wb_queue_pkg.sv
// rf_wb_queue_pkg
//   Shared definitions for the register-file writeback queue.
//   - DEF_DATA_W / DEF_SEL_W : default register data and select widths
//   - NUM_REGS               : number of registers addressed by a select
//   - wbq_entry_t            : one queued writeback {regsel, data}
package rf_wb_queue_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_SEL_W  = 3;
   localparam int NUM_REGS   = 2 ** DEF_SEL_W;

   typedef struct packed {
      logic [DEF_SEL_W-1:0]  regsel;
      logic [DEF_DATA_W-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/rf_wb_queue_fwd_sel.sv
// wbq_fwd_sel
//   Forwarding lookup over the writeback queue for one read select.
//   Ports:
//     regsel, data : queue storage, indexed physically
//     valid        : per-slot occupancy mask
//     head         : physical index of the oldest entry
//     sel          : register select being read
//     hit          : some valid entry targets sel
//     hit_data     : data of the youngest such entry, 0 when no hit
module wbq_fwd_sel
   import rf_wb_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SEL_W  = DEF_SEL_W,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic [SEL_W-1:0]  regsel [DEPTH],
   input  logic [DATA_W-1:0] data   [DEPTH],
   input  logic [DEPTH-1:0]  valid,
   input  logic [PTR_W-1:0]  head,
   input  logic [SEL_W-1:0]  sel,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   logic [PTR_W-1:0] idx;

   // Walk slots oldest to youngest starting at head, so the last match wins.
   // Scanning by physical index would pick the wrong entry after a wrap.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (valid[idx] && (regsel[idx] == sel)) begin
            hit      = 1'b1;
            hit_data = data[idx];
         end
      end
   end

endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue
//   In-order writeback queue in front of the register file write port.
//   Ports:
//     clk, rst                         : clock, synchronous active-high reset
//     enq_valid/enq_regsel/enq_data    : writeback request from the pipeline
//     enq_ready                        : queue not full
//     hold                             : suppress draining this cycle
//     write/writeregsel/writedata      : register file write port (head entry)
//     read1regsel/read2regsel          : read selects for forwarding lookup
//     fwd1valid/fwd1data, fwd2*        : youngest queued value per read select
//     pending                          : bitmap of registers with queued writes
//     err                              : sticky, a request arrived while full
//
// Handshake: a request transfers on a clock edge where enq_valid and
// enq_ready are both high. enq_ready depends only on the occupancy before the
// edge (a same-cycle drain does not free a slot). enq_valid while enq_ready
// is low drops the request and sets err until reset.
module rf_wb_queue
   import rf_wb_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enq_valid,
   input  logic [SEL_W-1:0]     enq_regsel,
   input  logic [DATA_W-1:0]    enq_data,
   output logic                 enq_ready,
   input  logic                 hold,
   output logic                 write,
   output logic [SEL_W-1:0]     writeregsel,
   output logic [DATA_W-1:0]    writedata,
   input  logic [SEL_W-1:0]     read1regsel,
   input  logic [SEL_W-1:0]     read2regsel,
   output logic                 fwd1valid,
   output logic [DATA_W-1:0]    fwd1data,
   output logic                 fwd2valid,
   output logic [DATA_W-1:0]    fwd2data,
   output logic [2**SEL_W-1:0]  pending,
   output logic                 err
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [SEL_W-1:0]  regsel_q [DEPTH];
   logic [DATA_W-1:0] data_q   [DEPTH];
   logic [PTR_W-1:0]  head, tail;
   logic [PTR_W:0]    count;
   logic [DEPTH-1:0]  valid;
   logic              not_empty;
   logic              enq_fire;

   assign not_empty   = (count != '0);
   assign enq_ready   = (count != (PTR_W+1)'(DEPTH));
   assign enq_fire    = enq_valid && enq_ready;
   assign write       = not_empty && !hold;
   assign writeregsel = not_empty ? regsel_q[head] : '0;
   assign writedata   = not_empty ? data_q[head]   : '0;

   // A slot is occupied when its distance from head is below count.
   always_comb begin
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = ({1'b0, PTR_W'(i) - head} < count);
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i]) pending[regsel_q[i]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (enq_fire) tail <= tail + 1'b1;
         if (write)    head <= head + 1'b1;
         case ({enq_fire, write})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (enq_valid && !enq_ready) err <= 1'b1;
      end
   end

   // Payload needs no reset: occupancy gates every use of it.
   always_ff @(posedge clk) begin
      if (!rst && enq_fire) begin
         regsel_q[tail] <= enq_regsel;
         data_q[tail]   <= enq_data;
      end
   end

   wbq_fwd_sel #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .PTR_W(PTR_W)
   ) u_fwd1 (
      .regsel(regsel_q), .data(data_q), .valid(valid), .head(head),
      .sel(read1regsel), .hit(fwd1valid), .hit_data(fwd1data)
   );

   wbq_fwd_sel #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .PTR_W(PTR_W)
   ) u_fwd2 (
      .regsel(regsel_q), .data(data_q), .valid(valid), .head(head),
      .sel(read2regsel), .hit(fwd2valid), .hit_data(fwd2data)
   );

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Write-side companion to the 8x16 register file with bypass.
- Buffers pending register writebacks from the pipeline in a small in-order queue.
- Drains at most one entry per cycle onto the RF single write port (write, writeregsel, writedata).
- Gives the read side a pending-register bitmap (for stall decisions) and youngest-value forwarding for two read selects.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- DATA_W, 16, register data width.
- SEL_W, 3, register select width; the register file has 2**SEL_W registers.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enq_valid  in  1  writeback request this cycle.
- enq_regsel  in  SEL_W  destination register of the request.
- enq_data  in  DATA_W  value to write.
- enq_ready  out  1  queue can accept a request this cycle.
- hold  in  1  suppress draining this cycle.
- write  out  1  RF write enable.
- writeregsel  out  SEL_W  RF write select.
- writedata  out  DATA_W  RF write data.
- read1regsel  in  SEL_W  read port 1 select, for forwarding lookup.
- read2regsel  in  SEL_W  read port 2 select, for forwarding lookup.
- fwd1valid  out  1  queue holds a pending write to read1regsel.
- fwd1data  out  DATA_W  youngest queued value for read1regsel.
- fwd2valid  out  1  same as fwd1valid, for read2regsel.
- fwd2data  out  DATA_W  same as fwd1data, for read2regsel.
- pending  out  2**SEL_W  bit r set iff any valid entry targets register r.
- err  out  1  sticky overflow flag.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Storage: circular buffer of DEPTH entries {regsel, data}, with head pointer, tail pointer and count (0..DEPTH).
- Reset: count=0, pointers=0, err=0. All outputs read 0 while empty: write, writeregsel, writedata, fwd*, pending. enq_ready=1 after reset.
- enq_ready = (count != DEPTH). This is not relaxed by a same-cycle drain, so there is no full pass-through.
- Enqueue: when enq_valid && enq_ready, the entry is stored at the tail at the clock edge and tail increments mod DEPTH.
- Drain (combinational from the head):
  - write = (count != 0) && !hold.
  - writeregsel and writedata = head entry when count != 0, else 0.
  - When write=1, head increments mod DEPTH at the clock edge; the RF captures the value on the same edge.
- Latency: a request accepted at edge N appears on write at cycle N+1 if the queue was empty and hold=0.
- Count update per cycle: +1 for enqueue only, -1 for drain only, unchanged when both occur.
- Order: strict FIFO. Multiple entries for the same register are drained oldest first, so the final RF value is the youngest.
- Overflow: enq_valid && !enq_ready drops the request and sets err=1. err stays set until rst.
- pending: OR over valid entries of the one-hot decode of regsel. It reflects state before the current edge and includes the head being drained this cycle.
- Forwarding:
  - fwdNvalid=1 iff some valid entry has regsel == readNregsel.
  - fwdNdata = data of the youngest such entry, by age from head, not by physical index.
  - The head being drained this cycle still forwards, consistent with RF bypass.
  - An enq in the same cycle is not forwarded.
- Wrap-around: age ordering and pending are correct across pointer wrap. Tested at DEPTH=4 after more than 8 enqueues.
- hold while full: no drain and enq_ready=0; a requester that ignores enq_ready raises err.
- Reset mid-operation: all queued writes are discarded, not drained; write=0 in the cycle after rst.

Decomposition:
- Shared package: DATA_W and SEL_W defaults; the NUM_REGS=2**SEL_W constant; entry record type {regsel, data}.
- One sub-module: wbq_fwd_sel. Inputs are the entry array, valid mask, head pointer and a select; outputs are valid and youngest data.
- wbq_fwd_sel is instantiated twice, for read1 and read2.
- FIFO storage and pointers stay in rf_wb_queue.

Test Plan:
- Single write: after reset, enq r3=16'hBEEF once. Next cycle write=1, writeregsel=3, writedata=BEEF, pending=8'h08, fwd1valid=1 with read1regsel=3. The following cycle write=0 and pending=0.
- Same-register ordering: hold=1; enq r2=0001, r2=0002, r5=0055. Then fwd1data=0002 with read1regsel=2 and pending=8'h24. Release hold: writes issue r2=0001, r2=0002, r5=0055 on consecutive cycles.
- Full/overflow: hold=1; enq 4 entries, then enq_ready=0. Fifth enq_valid sets err=1 and that entry never appears. Release hold: exactly 4 writes. err stays 1 until rst.
- Simultaneous enq+drain: stream one enq per cycle with hold=0 for 10 cycles. count stays at 1, enq_ready stays 1, and the writes match the input sequence with 1-cycle lag across pointer wrap.
- Forward priority across wrap: fill and drain to move head to index 3. Then enq r7=0AAA, r7=0BBB (the second wraps to index 0). fwd2data=0BBB with read2regsel=7.
- Reset mid-operation: 3 entries queued with hold=1, assert rst for one cycle. After rst: write=0, pending=0, fwd*valid=0, enq_ready=1, err=0, and no stale writes after hold drops.
